// File: rtl/lsu_pkg.sv
// Shared constants and types for the load/store unit initiator.
package lsu_pkg;

  localparam int XLEN   = 64;
  localparam int MASK_W = XLEN / 8;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_RESP
  } lsu_state_t;

endpackage

// File: rtl/lsu_mem_initiator_if.sv
// Data-memory request/response port between the LSU (master) and the memory block (slave).
interface lsu_mem_initiator_if;
  import lsu_pkg::*;

  logic              mem_req_valid;
  logic              mem_req_ready;
  logic              mem_req_wen;
  logic [XLEN-1:0]   mem_addr;
  logic [XLEN-1:0]   mem_wdata;
  logic [MASK_W-1:0] mem_wmask;
  logic              mem_resp_valid;
  logic [XLEN-1:0]   mem_rdata;

  modport master (
    output mem_req_valid, mem_req_wen, mem_addr, mem_wdata, mem_wmask,
    input  mem_req_ready, mem_resp_valid, mem_rdata
  );

  modport slave (
    input  mem_req_valid, mem_req_wen, mem_addr, mem_wdata, mem_wmask,
    output mem_req_ready, mem_resp_valid, mem_rdata
  );

endinterface

// File: rtl/lsu_align.sv
// Byte-lane steering for stores and alignment/extension for loads.
// The misalign output exists only when LSU_MISALIGN_CHK_EN is defined.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]        funct3,
  input  logic [2:0]        off,
  input  logic [XLEN-1:0]   sdata,
  input  logic [XLEN-1:0]   rdata,
  output logic [MASK_W-1:0] wmask,
  output logic [XLEN-1:0]   wdata,
  output logic [XLEN-1:0]   ldata
`ifdef LSU_MISALIGN_CHK_EN
  ,
  output logic              misalign
`endif
);

  logic [5:0]        sh;
  logic [MASK_W-1:0] base_mask;
  logic [XLEN-1:0]   shifted;

  function automatic logic [XLEN-1:0] extend(input logic [2:0] f3, input logic [XLEN-1:0] v);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] w;
    b = v[7:0];
    h = v[15:0];
    w = v[31:0];
    case (f3)
      F3_B:    return XLEN'(b);
      F3_H:    return XLEN'(h);
      F3_W:    return XLEN'(w);
      F3_BU:   return XLEN'(v[7:0]);
      F3_HU:   return XLEN'(v[15:0]);
      F3_WU:   return XLEN'(v[31:0]);
      default: return v;
    endcase
  endfunction

  assign sh = {off, 3'b000};

  always_comb begin
    case (funct3[1:0])
      2'd0:    base_mask = 8'h01;
      2'd1:    base_mask = 8'h03;
      2'd2:    base_mask = 8'h0F;
      default: base_mask = 8'hFF;
    endcase
  end

  // Lanes past the end of the doubleword fall off the shift and are dropped.
  assign wmask   = base_mask << off;
  assign wdata   = sdata << sh;
  assign shifted = rdata >> sh;
  assign ldata   = extend(funct3, shifted);

`ifdef LSU_MISALIGN_CHK_EN
  always_comb begin
    case (funct3[1:0])
      2'd0:    misalign = 1'b0;
      2'd1:    misalign = off[0];
      2'd2:    misalign = |off[1:0];
      default: misalign = |off;
    endcase
  end
`endif

endmodule

// File: rtl/lsu_mem_initiator.sv
// Load/store unit initiator: one op in flight, EXU -> data-memory port -> write-back.
// Optional misaligned-access trap enabled by defining LSU_MISALIGN_CHK_EN.
module lsu_mem_initiator #(
  parameter int XLEN   = lsu_pkg::XLEN,
  parameter int MASK_W = lsu_pkg::MASK_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic              ex_is_load,
  input  logic              ex_is_store,
  input  logic [2:0]        ex_funct3,
  input  logic [XLEN-1:0]   ex_addr,
  input  logic [XLEN-1:0]   ex_sdata,
  lsu_mem_initiator_if.master mem,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [XLEN-1:0]   wb_data,
  output logic              wb_err
);
  import lsu_pkg::*;

  lsu_state_t        state;
  logic [2:0]        funct3_r;
  logic [2:0]        off_r;
  logic              is_load_r;

  logic [2:0]        al_funct3;
  logic [2:0]        al_off;
  logic [MASK_W-1:0] al_wmask;
  logic [XLEN-1:0]   al_wdata;
  logic [XLEN-1:0]   al_ldata;
  logic              is_access;
  logic              is_st;

  assign is_access = ex_is_load | ex_is_store;
  assign is_st     = ex_is_store & ~ex_is_load;

  // Store lanes come from the live EXU op; load extension uses the captured op.
  assign al_funct3 = (state == ST_IDLE) ? ex_funct3    : funct3_r;
  assign al_off    = (state == ST_IDLE) ? ex_addr[2:0] : off_r;

`ifdef LSU_MISALIGN_CHK_EN
  logic al_mis;
`else
  assign wb_err = 1'b0;
`endif

  lsu_align u_align (
    .funct3   (al_funct3),
    .off      (al_off),
    .sdata    (ex_sdata),
    .rdata    (mem.mem_rdata),
    .wmask    (al_wmask),
    .wdata    (al_wdata),
    .ldata    (al_ldata)
`ifdef LSU_MISALIGN_CHK_EN
    ,
    .misalign (al_mis)
`endif
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= ST_IDLE;
      ex_ready          <= 1'b1;
      mem.mem_req_valid <= 1'b0;
      mem.mem_req_wen   <= 1'b0;
      mem.mem_addr      <= '0;
      mem.mem_wdata     <= '0;
      mem.mem_wmask     <= '0;
      wb_valid          <= 1'b0;
      wb_data           <= '0;
`ifdef LSU_MISALIGN_CHK_EN
      wb_err            <= 1'b0;
`endif
      funct3_r          <= '0;
      off_r             <= '0;
      is_load_r         <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (ex_valid) begin
            ex_ready  <= 1'b0;
            funct3_r  <= ex_funct3;
            off_r     <= ex_addr[2:0];
            is_load_r <= ex_is_load;
            if (!is_access) begin
              state    <= ST_RESP;
              wb_valid <= 1'b1;
              wb_data  <= '0;
            end
`ifdef LSU_MISALIGN_CHK_EN
            else if (al_mis) begin
              state    <= ST_RESP;
              wb_valid <= 1'b1;
              wb_err   <= 1'b1;
              wb_data  <= ex_addr;
            end
`endif
            else begin
              state             <= ST_REQ;
              mem.mem_req_valid <= 1'b1;
              mem.mem_req_wen   <= is_st;
              mem.mem_addr      <= {ex_addr[XLEN-1:3], 3'b000};
              mem.mem_wdata     <= is_st ? al_wdata : '0;
              mem.mem_wmask     <= is_st ? al_wmask : '0;
            end
          end
        end
        ST_REQ: begin
          if (mem.mem_req_ready) begin
            mem.mem_req_valid <= 1'b0;
            state             <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (mem.mem_resp_valid) begin
            wb_valid <= 1'b1;
            wb_data  <= is_load_r ? al_ldata : '0;
            state    <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (wb_ready) begin
            wb_valid <= 1'b0;
            wb_data  <= '0;
`ifdef LSU_MISALIGN_CHK_EN
            wb_err   <= 1'b0;
`endif
            ex_ready <= 1'b1;
            state    <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Self-checking bench for lsu_mem_initiator: directed cases plus randomized ops
// against a byte-level reference model; honours LSU_MISALIGN_CHK_EN.
module tb_lsu_mem_initiator;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_ready, ex_is_load, ex_is_store;
  logic [2:0]  ex_funct3;
  logic [63:0] ex_addr, ex_sdata;
  logic        wb_valid, wb_ready, wb_err;
  logic [63:0] wb_data;

  lsu_mem_initiator_if mem_if ();

  lsu_mem_initiator dut (
    .clk         (clk),
    .rst         (rst),
    .ex_valid    (ex_valid),
    .ex_ready    (ex_ready),
    .ex_is_load  (ex_is_load),
    .ex_is_store (ex_is_store),
    .ex_funct3   (ex_funct3),
    .ex_addr     (ex_addr),
    .ex_sdata    (ex_sdata),
    .mem         (mem_if),
    .wb_valid    (wb_valid),
    .wb_ready    (wb_ready),
    .wb_data     (wb_data),
    .wb_err      (wb_err)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Observations from the last op
  logic [63:0] o_addr, o_wdata, o_wbd;
  logic [7:0]  o_mask;
  logic        o_wen, o_err, o_exr_end;
  int          o_nreq, o_lat;
  bit          o_stable, o_exr_bad;

  // Reference model: byte-at-a-time view of the lane rules
  function automatic int ref_size(input logic [2:0] f3);
    return 1 << int'(f3[1:0]);
  endfunction

  function automatic logic [7:0] ref_wmask(input logic [2:0] f3, input logic [63:0] a);
    logic [7:0] m = 8'h00;
    int sz = ref_size(f3);
    int off = int'(a[2:0]);
    for (int b = 0; b < 8; b++) if (b >= off && b < off + sz) m[b] = 1'b1;
    return m;
  endfunction

  function automatic logic [63:0] ref_wdata(input logic [63:0] sd, input logic [63:0] a);
    logic [63:0] r = 64'd0;
    int off = int'(a[2:0]);
    for (int b = 0; b < 8; b++) if (b >= off) r[8*b +: 8] = sd[8*(b-off) +: 8];
    return r;
  endfunction

  function automatic logic [63:0] ref_load(input logic [2:0] f3, input logic [63:0] a, input logic [63:0] rd);
    logic [63:0] r = 64'd0;
    int sz = ref_size(f3);
    int off = int'(a[2:0]);
    for (int i = 0; i < sz; i++) if (off + i < 8) r[8*i +: 8] = rd[8*(off+i) +: 8];
    if (!f3[2] && r[8*sz-1]) for (int i = sz; i < 8; i++) r[8*i +: 8] = 8'hFF;
    return r;
  endfunction

  function automatic bit ref_mis(input logic [2:0] f3, input logic [63:0] a);
    return (int'(a[2:0]) % ref_size(f3)) != 0;
  endfunction

  // Drives one op and plays memory/WBU with the given wait counts.
  task automatic do_op(input bit ld, input bit st, input logic [2:0] f3, input logic [63:0] addr,
                       input logic [63:0] sd, input logic [63:0] rd,
                       input int rq_d, input int rs_d, input int wb_d);
    int rq_c = 0, rs_c = 0, wb_c = 0, w = 0;
    bit hs_done = 0, resp_done = 0, fin = 0, first_req = 1, first_wb = 1;
    o_addr = 0; o_wdata = 0; o_wbd = 0; o_mask = 0; o_wen = 0; o_err = 0;
    o_nreq = 0; o_lat = -1; o_stable = 1; o_exr_bad = 0; o_exr_end = 0;
    while (ex_ready !== 1'b1 && w < 50) begin @(negedge clk); w++; end
    ex_valid = 1; ex_is_load = ld; ex_is_store = st; ex_funct3 = f3; ex_addr = addr; ex_sdata = sd;
    mem_if.mem_rdata = rd;
    @(negedge clk);
    ex_valid = 0; ex_is_load = 0; ex_is_store = 0;
    ex_funct3 = 3'($urandom); ex_addr = {$urandom, $urandom}; ex_sdata = {$urandom, $urandom};
    for (int k = 1; k <= 100 && !fin; k++) begin
      mem_if.mem_resp_valid = 0; mem_if.mem_req_ready = 0; wb_ready = 0;
      if (ex_ready !== 1'b0) o_exr_bad = 1;
      if (hs_done && !resp_done) begin
        if (rs_c == rs_d) begin mem_if.mem_resp_valid = 1; resp_done = 1; end
        else rs_c++;
      end
      if (mem_if.mem_req_valid === 1'b1) begin
        if (first_req) begin
          o_addr = mem_if.mem_addr; o_wdata = mem_if.mem_wdata;
          o_mask = mem_if.mem_wmask; o_wen = mem_if.mem_req_wen; first_req = 0;
        end else if (mem_if.mem_addr !== o_addr || mem_if.mem_wdata !== o_wdata ||
                     mem_if.mem_wmask !== o_mask || mem_if.mem_req_wen !== o_wen) o_stable = 0;
        if (rq_c == rq_d) begin mem_if.mem_req_ready = 1; o_nreq++; hs_done = 1; end
        else rq_c++;
      end
      if (wb_valid === 1'b1) begin
        if (first_wb) begin o_lat = k; o_wbd = wb_data; o_err = wb_err; first_wb = 0; end
        else if (wb_data !== o_wbd || wb_err !== o_err) o_stable = 0;
        if (wb_c == wb_d) begin wb_ready = 1; fin = 1; end
        else wb_c++;
      end
      @(negedge clk);
    end
    mem_if.mem_resp_valid = 0; mem_if.mem_req_ready = 0; wb_ready = 0;
    if (!fin) o_lat = -1;
    o_exr_end = ex_ready;
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (3) @(negedge clk);
    rst = 0;
    @(negedge clk);
    n_cmp++; if (ex_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ex_ready got=%b exp=1", ex_ready); end
    n_cmp++; if (mem_if.mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL rst_req_valid got=%b exp=0", mem_if.mem_req_valid); end
    n_cmp++; if (wb_valid !== 1'b0 || wb_err !== 1'b0) begin n_fail++; $display("FAIL rst_wb got=%b/%b exp=0/0", wb_valid, wb_err); end
    n_cmp++; if (wb_data !== 64'd0) begin n_fail++; $display("FAIL rst_wb_data got=%h exp=0", wb_data); end
    n_cmp++; if ({mem_if.mem_addr, mem_if.mem_wdata, mem_if.mem_wmask, mem_if.mem_req_wen} !== 137'd0) begin
      n_fail++; $display("FAIL rst_mem_fields got=%h/%h/%h/%b exp=0", mem_if.mem_addr, mem_if.mem_wdata, mem_if.mem_wmask, mem_if.mem_req_wen); end
  endtask

  task automatic test_store_sd();
    do_op(0, 1, 3'b011, 64'h80000008, 64'h1122334455667788, 64'hDEADBEEF, 0, 0, 0);
    n_cmp++; if (o_addr !== 64'h80000008) begin n_fail++; $display("FAIL sd_addr got=%h exp=80000008", o_addr); end
    n_cmp++; if (o_mask !== 8'hFF) begin n_fail++; $display("FAIL sd_wmask got=%h exp=ff", o_mask); end
    n_cmp++; if (o_wdata !== 64'h1122334455667788) begin n_fail++; $display("FAIL sd_wdata got=%h exp=1122334455667788", o_wdata); end
    n_cmp++; if (o_wen !== 1'b1) begin n_fail++; $display("FAIL sd_wen got=%b exp=1", o_wen); end
    n_cmp++; if (o_lat !== 3) begin n_fail++; $display("FAIL sd_latency got=%0d exp=3", o_lat); end
    n_cmp++; if (o_wbd !== 64'd0) begin n_fail++; $display("FAIL sd_wb_data got=%h exp=0", o_wbd); end
  endtask

  task automatic test_store_sb();
    do_op(0, 1, 3'b000, 64'h80000005, 64'h00000000000000AB, 64'd0, 0, 0, 0);
    n_cmp++; if (o_addr !== 64'h80000000) begin n_fail++; $display("FAIL sb_addr got=%h exp=80000000", o_addr); end
    n_cmp++; if (o_mask !== 8'h20) begin n_fail++; $display("FAIL sb_wmask got=%h exp=20", o_mask); end
    n_cmp++; if (o_wdata !== 64'h0000AB0000000000) begin n_fail++; $display("FAIL sb_wdata got=%h exp=0000ab0000000000", o_wdata); end
  endtask

  task automatic test_load_lb_lbu();
    do_op(1, 0, 3'b000, 64'h80000003, 64'd0, 64'h00000000F0000000, 0, 0, 0);
    n_cmp++; if (o_wbd !== 64'hFFFFFFFFFFFFFFF0) begin n_fail++; $display("FAIL lb_data got=%h exp=fffffffffffffff0", o_wbd); end
    n_cmp++; if (o_mask !== 8'h00 || o_wen !== 1'b0) begin n_fail++; $display("FAIL lb_read_fields got=%h/%b exp=00/0", o_mask, o_wen); end
    do_op(1, 0, 3'b100, 64'h80000003, 64'd0, 64'h00000000F0000000, 0, 0, 0);
    n_cmp++; if (o_wbd !== 64'h00000000000000F0) begin n_fail++; $display("FAIL lbu_data got=%h exp=f0", o_wbd); end
  endtask

  task automatic test_stall();
    logic [63:0] rd = {$urandom, $urandom};
    do_op(1, 0, 3'b010, 64'h80000004, 64'd0, rd, 4, 2, 3);
    n_cmp++; if (o_stable !== 1'b1) begin n_fail++; $display("FAIL stall_stable got=%b exp=1", o_stable); end
    n_cmp++; if (o_exr_bad !== 1'b0) begin n_fail++; $display("FAIL stall_ex_ready_busy got=%b exp=0", o_exr_bad); end
    n_cmp++; if (o_nreq !== 1) begin n_fail++; $display("FAIL stall_nreq got=%0d exp=1", o_nreq); end
    n_cmp++; if (o_wbd !== ref_load(3'b010, 64'h80000004, rd)) begin n_fail++; $display("FAIL stall_data got=%h exp=%h", o_wbd, ref_load(3'b010, 64'h80000004, rd)); end
    n_cmp++; if (o_exr_end !== 1'b1) begin n_fail++; $display("FAIL stall_ex_ready_after got=%b exp=1", o_exr_end); end
  endtask

  task automatic test_reset_mid();
    bit wb_seen = 0;
    @(negedge clk);
    ex_valid = 1; ex_is_load = 1; ex_is_store = 0; ex_funct3 = 3'b011; ex_addr = 64'h80000010;
    mem_if.mem_rdata = 64'h0123456789ABCDEF;
    @(negedge clk);
    ex_valid = 0; ex_is_load = 0;
    mem_if.mem_req_ready = 1;
    @(negedge clk);
    mem_if.mem_req_ready = 0;
    rst = 1;
    @(negedge clk);
    rst = 0;
    mem_if.mem_resp_valid = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (wb_valid !== 1'b0) wb_seen = 1;
    end
    mem_if.mem_resp_valid = 0;
    n_cmp++; if (wb_seen !== 1'b0) begin n_fail++; $display("FAIL rstmid_stale_wb got=%b exp=0", wb_seen); end
    n_cmp++; if (ex_ready !== 1'b1 || mem_if.mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_idle got=%b/%b exp=1/0", ex_ready, mem_if.mem_req_valid); end
    n_cmp++; if (mem_if.mem_addr !== 64'd0) begin n_fail++; $display("FAIL rstmid_addr got=%h exp=0", mem_if.mem_addr); end
    do_op(1, 0, 3'b001, 64'h80000006, 64'd0, 64'h8001000000000000, 0, 0, 0);
    n_cmp++; if (o_wbd !== 64'hFFFFFFFFFFFF8001 || o_lat !== 3) begin n_fail++; $display("FAIL rstmid_next_op got=%h/%0d exp=ffffffffffff8001/3", o_wbd, o_lat); end
  endtask

  task automatic test_misalign();
    do_op(0, 1, 3'b001, 64'h80000001, 64'h000000000000BEEF, 64'd0, 0, 0, 0);
`ifdef LSU_MISALIGN_CHK_EN
    n_cmp++; if (o_nreq !== 0) begin n_fail++; $display("FAIL mis_nreq got=%0d exp=0", o_nreq); end
    n_cmp++; if (o_err !== 1'b1) begin n_fail++; $display("FAIL mis_err got=%b exp=1", o_err); end
    n_cmp++; if (o_wbd !== 64'h80000001) begin n_fail++; $display("FAIL mis_data got=%h exp=80000001", o_wbd); end
`else
    n_cmp++; if (o_mask !== 8'h06) begin n_fail++; $display("FAIL mis_wmask got=%h exp=06", o_mask); end
    n_cmp++; if (o_err !== 1'b0 || o_nreq !== 1) begin n_fail++; $display("FAIL mis_complete got=%b/%0d exp=0/1", o_err, o_nreq); end
`endif
  endtask

  task automatic test_noop_and_both();
    do_op(0, 0, 3'b011, 64'h80000040, 64'hFFFF, 64'hFFFF, 0, 0, 0);
    n_cmp++; if (o_nreq !== 0 || o_wbd !== 64'd0 || o_lat !== 1) begin n_fail++; $display("FAIL noop got=%0d/%h/%0d exp=0/0/1", o_nreq, o_wbd, o_lat); end
    do_op(1, 1, 3'b110, 64'h80000044, 64'hFFFFFFFF, 64'h89ABCDEF00000000, 0, 0, 0);
    n_cmp++; if (o_wen !== 1'b0 || o_wbd !== 64'h0000000089ABCDEF) begin n_fail++; $display("FAIL both_as_load got=%b/%h exp=0/0000000089abcdef", o_wen, o_wbd); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 60; it++) begin
      int kind = int'($urandom_range(0, 9));
      bit ld = (kind >= 1 && kind <= 4) || kind == 9;
      bit st = (kind >= 5);
      logic [2:0] f3 = ld ? 3'($urandom_range(0, 6)) : 3'($urandom_range(0, 3));
      logic [63:0] a = {$urandom, $urandom};
      logic [63:0] sd = {$urandom, $urandom};
      logic [63:0] rd = {$urandom, $urandom};
      int rq_d = int'($urandom_range(0, 3));
      int rs_d = int'($urandom_range(0, 3));
      int wb_d = int'($urandom_range(0, 3));
      bit acc = ld | st;
      bit st_eff = st & ~ld;
      bit mis;
      int exp_nreq;
      logic [63:0] exp_wbd;
`ifdef LSU_MISALIGN_CHK_EN
      mis = acc && ref_mis(f3, a);
`else
      mis = 0;
`endif
      exp_nreq = (acc && !mis) ? 1 : 0;
      exp_wbd  = mis ? a : (ld ? ref_load(f3, a, rd) : 64'd0);
      do_op(ld, st, f3, a, sd, rd, rq_d, rs_d, wb_d);
      n_cmp++; if (o_nreq !== exp_nreq) begin n_fail++; $display("FAIL rnd%0d_nreq got=%0d exp=%0d", it, o_nreq, exp_nreq); end
      n_cmp++; if (o_wbd !== exp_wbd) begin n_fail++; $display("FAIL rnd%0d_wb_data got=%h exp=%h", it, o_wbd, exp_wbd); end
      n_cmp++; if (o_err !== mis) begin n_fail++; $display("FAIL rnd%0d_wb_err got=%b exp=%b", it, o_err, mis); end
      n_cmp++; if (o_lat !== (exp_nreq == 1 ? 3 + rq_d + rs_d : 1)) begin
        n_fail++; $display("FAIL rnd%0d_latency got=%0d exp=%0d", it, o_lat, (exp_nreq == 1 ? 3 + rq_d + rs_d : 1)); end
      n_cmp++; if (o_stable !== 1'b1 || o_exr_bad !== 1'b0 || o_exr_end !== 1'b1) begin
        n_fail++; $display("FAIL rnd%0d_handshake got=%b/%b/%b exp=1/0/1", it, o_stable, o_exr_bad, o_exr_end); end
      if (exp_nreq == 1) begin
        n_cmp++; if (o_addr !== {a[63:3], 3'b000} || o_wen !== st_eff) begin
          n_fail++; $display("FAIL rnd%0d_req got=%h/%b exp=%h/%b", it, o_addr, o_wen, {a[63:3], 3'b000}, st_eff); end
        n_cmp++; if (o_mask !== (st_eff ? ref_wmask(f3, a) : 8'h00)) begin
          n_fail++; $display("FAIL rnd%0d_wmask got=%h exp=%h", it, o_mask, (st_eff ? ref_wmask(f3, a) : 8'h00)); end
        if (st_eff) begin
          n_cmp++; if (o_wdata !== ref_wdata(sd, a)) begin
            n_fail++; $display("FAIL rnd%0d_wdata got=%h exp=%h", it, o_wdata, ref_wdata(sd, a)); end
        end
      end
    end
  endtask

  initial begin
    rst = 1; ex_valid = 0; ex_is_load = 0; ex_is_store = 0; ex_funct3 = 0; ex_addr = 0; ex_sdata = 0;
    wb_ready = 0;
    mem_if.mem_req_ready = 0; mem_if.mem_resp_valid = 0; mem_if.mem_rdata = 64'hCAFEF00DCAFEF00D;
    test_reset();
    test_store_sd();
    test_store_sb();
    test_load_lb_lbu();
    test_stall();
    test_reset_mid();
    test_misalign();
    test_noop_and_both();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
